// File: rtl/multiplier.sv
// IEEE 754 single-precision multiplier with stb/ack stream handshakes on a, b and z.
// Iterative 24-cycle shift-add mantissa product, round-to-nearest-even.
module multiplier (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL_CASES, NORMALISE_A, NORMALISE_B,
    MULTIPLY_0, MULTIPLY_1, MULTIPLY_2, NORMALISE_1, NORMALISE_2,
    ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] E_ZERO = -10'sd127;
  localparam logic signed [9:0] E_INF  = 10'sd128;
  localparam logic signed [9:0] E_DEN  = -10'sd126;
  localparam logic signed [9:0] E_MAX  = 10'sd127;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
  logic [23:0]        a_m_q, a_m_d, b_m_q, b_m_d, z_m_q, z_m_d;
  logic signed [9:0]  a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic               a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic               guard_q, guard_d, round_bit_q, round_bit_d, sticky_q, sticky_d;
  logic [47:0]        product_q, product_d;
  logic [4:0]         count_q, count_d;
  logic               input_a_ack_q, input_a_ack_d, input_b_ack_q, input_b_ack_d;
  logic               output_z_stb_q, output_z_stb_d;
  logic [31:0]        output_z_q, output_z_d;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sp_s;

  assign a_nan  = (a_e_q == E_INF) && (a_m_q != '0);
  assign b_nan  = (b_e_q == E_INF) && (b_m_q != '0);
  assign a_inf  = (a_e_q == E_INF) && (a_m_q == '0);
  assign b_inf  = (b_e_q == E_INF) && (b_m_q == '0);
  assign a_zero = (a_e_q == E_ZERO) && (a_m_q == '0);
  assign b_zero = (b_e_q == E_ZERO) && (b_m_q == '0);
  assign sp_s   = a_s_q ^ b_s_q;

  always_comb begin
    state_d        = state_q;
    a_d            = a_q;
    b_d            = b_q;
    z_d            = z_q;
    a_m_d          = a_m_q;
    b_m_d          = b_m_q;
    z_m_d          = z_m_q;
    a_e_d          = a_e_q;
    b_e_d          = b_e_q;
    z_e_d          = z_e_q;
    a_s_d          = a_s_q;
    b_s_d          = b_s_q;
    z_s_d          = z_s_q;
    guard_d        = guard_q;
    round_bit_d    = round_bit_q;
    sticky_d       = sticky_q;
    product_d      = product_q;
    count_d        = count_q;
    input_a_ack_d  = input_a_ack_q;
    input_b_ack_d  = input_b_ack_q;
    output_z_stb_d = output_z_stb_q;
    output_z_d     = output_z_q;

    case (state_q)
      GET_A: begin
        input_a_ack_d = 1'b1;
        if (input_a_ack_q && input_a_stb) begin
          a_d           = input_a;
          input_a_ack_d = 1'b0;
          state_d       = GET_B;
        end
      end
      GET_B: begin
        input_b_ack_d = 1'b1;
        if (input_b_ack_q && input_b_stb) begin
          b_d           = input_b;
          input_b_ack_d = 1'b0;
          state_d       = UNPACK;
        end
      end
      UNPACK: begin
        a_m_d   = {1'b0, a_q[22:0]};
        b_m_d   = {1'b0, b_q[22:0]};
        a_e_d   = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        b_e_d   = $signed({2'b00, b_q[30:23]}) - 10'sd127;
        a_s_d   = a_q[31];
        b_s_d   = b_q[31];
        state_d = SPECIAL_CASES;
      end
      SPECIAL_CASES: begin
        state_d = PUT_Z;
        if (a_nan || b_nan) begin
          z_d = 32'hFFC0_0000;
        end else if (a_inf) begin
          z_d = b_zero ? 32'hFFC0_0000 : {sp_s, 8'hFF, 23'd0};
        end else if (b_inf) begin
          z_d = a_zero ? 32'hFFC0_0000 : {sp_s, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
          z_d = {sp_s, 31'd0};
        end else begin
          if (a_e_q == E_ZERO) a_e_d = E_DEN;
          else                 a_m_d[23] = 1'b1;
          if (b_e_q == E_ZERO) b_e_d = E_DEN;
          else                 b_m_d[23] = 1'b1;
          state_d = NORMALISE_A;
        end
      end
      NORMALISE_A: begin
        if (a_m_q[23]) begin
          state_d = NORMALISE_B;
        end else begin
          a_m_d = a_m_q << 1;
          a_e_d = a_e_q - 10'sd1;
        end
      end
      NORMALISE_B: begin
        if (b_m_q[23]) begin
          state_d = MULTIPLY_0;
        end else begin
          b_m_d = b_m_q << 1;
          b_e_d = b_e_q - 10'sd1;
        end
      end
      MULTIPLY_0: begin
        z_s_d     = a_s_q ^ b_s_q;
        z_e_d     = a_e_q + b_e_q + 10'sd1;
        product_d = '0;
        count_d   = '0;
        state_d   = MULTIPLY_1;
      end
      MULTIPLY_1: begin
        if (b_m_q[count_q]) product_d = product_q + ({24'd0, a_m_q} << count_q);
        count_d = count_q + 5'd1;
        if (count_q == 5'd23) state_d = MULTIPLY_2;
      end
      MULTIPLY_2: begin
        z_m_d       = product_q[47:24];
        guard_d     = product_q[23];
        round_bit_d = product_q[22];
        sticky_d    = |product_q[21:0];
        state_d     = NORMALISE_1;
      end
      NORMALISE_1: begin
        if (!z_m_q[23]) begin
          z_m_d       = {z_m_q[22:0], guard_q};
          guard_d     = round_bit_q;
          round_bit_d = 1'b0;
          z_e_d       = z_e_q - 10'sd1;
        end else begin
          state_d = NORMALISE_2;
        end
      end
      NORMALISE_2: begin
        if (z_e_q < E_DEN) begin
          z_m_d       = z_m_q >> 1;
          z_e_d       = z_e_q + 10'sd1;
          guard_d     = z_m_q[0];
          round_bit_d = guard_q;
          sticky_d    = sticky_q | round_bit_q;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          if (z_m_q == '1) z_e_d = z_e_q + 10'sd1;
        end
        state_d = PACK;
      end
      PACK: begin
        z_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
        if ((z_e_q == E_DEN) && !z_m_q[23]) z_d[30:23] = '0;
        if (z_e_q > E_MAX) z_d = {z_s_q, 8'hFF, 23'd0};
        state_d = PUT_Z;
      end
      PUT_Z: begin
        output_z_stb_d = 1'b1;
        output_z_d     = z_q;
        if (output_z_stb_q && output_z_ack) begin
          output_z_stb_d = 1'b0;
          state_d        = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= GET_A;
      input_a_ack_q  <= 1'b0;
      input_b_ack_q  <= 1'b0;
      output_z_stb_q <= 1'b0;
      output_z_q     <= '0;
    end else begin
      state_q        <= state_d;
      input_a_ack_q  <= input_a_ack_d;
      input_b_ack_q  <= input_b_ack_d;
      output_z_stb_q <= output_z_stb_d;
      output_z_q     <= output_z_d;
    end
    a_q         <= a_d;
    b_q         <= b_d;
    z_q         <= z_d;
    a_m_q       <= a_m_d;
    b_m_q       <= b_m_d;
    z_m_q       <= z_m_d;
    a_e_q       <= a_e_d;
    b_e_q       <= b_e_d;
    z_e_q       <= z_e_d;
    a_s_q       <= a_s_d;
    b_s_q       <= b_s_d;
    z_s_q       <= z_s_d;
    guard_q     <= guard_d;
    round_bit_q <= round_bit_d;
    sticky_q    <= sticky_d;
    product_q   <= product_d;
    count_q     <= count_d;
  end

  assign input_a_ack  = input_a_ack_q;
  assign input_b_ack  = input_b_ack_q;
  assign output_z_stb = output_z_stb_q;
  assign output_z     = output_z_q;

endmodule

// File: tb/tb_multiplier.sv
// Bench for multiplier: directed vector table, handshake/reset sequences,
// and random operands checked against a value-level IEEE single multiply model.
module tb_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = '0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] input_b = '0;
  logic        input_b_stb = 1'b0;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
  } vec_t;

  vec_t vecs[11];
  int   vectors = 0;
  int   miscompares = 0;
  logic aborted = 1'b0;
  logic both_seen = 1'b0;

  always @(negedge clk) begin
    if (input_a_ack && input_b_ack) both_seen <= 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    aborted = 1'b1;
    $display("FAIL %s: handshake timed out, got no response expected one", name);
  endtask

  task automatic send_a(input logic [31:0] a);
    int n;
    n = 0;
    input_a = a;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!input_a_ack) begin
      input_a_stb = 1'b0;
      timeout("a_ack");
      return;
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] b, input int delay);
    int n;
    n = 0;
    repeat (delay) begin
      @(posedge clk); #1;
    end
    input_b = b;
    input_b_stb = 1'b1;
    while (!input_b_ack && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!input_b_ack) begin
      input_b_stb = 1'b0;
      timeout("b_ack");
      return;
    end
    @(posedge clk); #1;
    input_b_stb = 1'b0;
  endtask

  // Counts edges from the b-capture edge to the edge that raises output_z_stb.
  task automatic wait_z(output logic [31:0] z, output int lat);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!output_z_stb && n < 2000);
    if (!output_z_stb) timeout("z_stb");
    z = output_z;
    lat = n;
  endtask

  task automatic accept_z();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input int b_delay,
                     output logic [31:0] z, output int lat);
    z = '0;
    lat = 0;
    if (aborted) return;
    send_a(a);
    if (aborted) return;
    send_b(b, b_delay);
    if (aborted) return;
    wait_z(z, lat);
    if (aborted) return;
    accept_z();
  endtask

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea_f, eb_f, ea, eb, msb, e_res, lsb, sh, expf;
    longint unsigned ma, mb, p, q, st;
    logic s, g;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    ea_f = int'(a[30:23]);
    eb_f = int'(b[30:23]);
    s = a[31] ^ b[31];
    a_nan  = (ea_f == 255) && (a[22:0] != 0);
    b_nan  = (eb_f == 255) && (b[22:0] != 0);
    a_inf  = (ea_f == 255) && (a[22:0] == 0);
    b_inf  = (eb_f == 255) && (b[22:0] == 0);
    a_zero = (ea_f == 0) && (a[22:0] == 0);
    b_zero = (eb_f == 0) && (b[22:0] == 0);
    if (a_nan || b_nan) return 32'hFFC0_0000;
    if (a_inf) return b_zero ? 32'hFFC0_0000 : {s, 8'hFF, 23'd0};
    if (b_inf) return a_zero ? 32'hFFC0_0000 : {s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {s, 31'd0};
    // value = significand * 2^exp with the significand as an integer
    ma = longint'(a[22:0]) + ((ea_f == 0) ? 64'd0 : 64'd8388608);
    mb = longint'(b[22:0]) + ((eb_f == 0) ? 64'd0 : 64'd8388608);
    ea = ((ea_f == 0) ? 1 : ea_f) - 150;
    eb = ((eb_f == 0) ? 1 : eb_f) - 150;
    p = ma * mb;
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    e_res = msb + ea + eb;
    lsb = ((e_res < -126) ? -126 : e_res) - 23;
    sh = lsb - (ea + eb);
    if (sh <= 0) begin
      q = p << (-sh);
      g = 1'b0;
      st = 0;
    end else if (sh >= 50) begin
      q = 0;
      g = 1'b0;
      st = 1;
    end else begin
      q = p >> sh;
      g = p[sh-1];
      st = p & ((64'd1 << (sh - 1)) - 64'd1);
    end
    if (g && (st != 0 || q[0])) q = q + 1;
    if (q == 64'd16777216) begin
      q = q >> 1;
      lsb = lsb + 1;
    end
    if (q < 64'd8388608) return {s, 8'h00, q[22:0]};
    expf = lsb + 150;
    if (expf >= 255) return {s, 8'hFF, 23'd0};
    return {s, expf[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    logic [31:0] specials [8];
    int mode;
    specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                 32'h7FC0_0000, 32'h7F80_0001, 32'h0000_0001, 32'h3F80_0000};
    r = $urandom;
    mode = $urandom_range(0, 5);
    case (mode)
      0: ;
      1, 2, 3: r[30:23] = 8'($urandom_range(100, 154));
      4: r[30:23] = 8'h00;
      default: r = specials[$urandom_range(0, 7)];
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] z, z0, ra, rb;
    int lat;
    logic stable;

    vecs[0]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 35};
    vecs[1]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 36};
    vecs[2]  = '{32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 3};
    vecs[3]  = '{32'h7F80_0000, 32'h0000_0000, 32'hFFC0_0000, 3};
    vecs[4]  = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 3};
    vecs[5]  = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 3};
    vecs[6]  = '{32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 0};
    vecs[7]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 0};
    vecs[8]  = '{32'h0000_0001, 32'h3F00_0000, 32'h0000_0000, 0};
    vecs[9]  = '{32'h0000_0003, 32'h3F00_0000, 32'h0000_0002, 0};
    vecs[10] = '{32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_a_ack", input_a_ack, 0);
    check("reset_b_ack", input_b_ack, 0);
    check("reset_z_stb", output_z_stb, 0);
    check("reset_z", output_z, 0);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run(vecs[i].a, vecs[i].b, 0, z, lat);
      check($sformatf("vec%0d_z", i), z, vecs[i].z);
      if (vecs[i].lat != 0) check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
    end

    // Output backpressure: z must be held while ack stays low.
    if (!aborted) begin
      send_a(32'h4000_0000);
      send_b(32'h4040_0000, 0);
      wait_z(z0, lat);
      check("bp_z", z0, 32'h40C0_0000);
      stable = 1'b1;
      repeat (10) begin
        @(posedge clk); #1;
        if (!output_z_stb || output_z !== z0) stable = 1'b0;
      end
      check("bp_hold_stable", stable, 1);
      output_z_ack = 1'b1;
      @(posedge clk); #1;
      output_z_ack = 1'b0;
      check("bp_stb_drop", output_z_stb, 0);
      check("bp_a_ack_not_yet", input_a_ack, 0);
      @(posedge clk); #1;
      check("bp_a_ack_rise", input_a_ack, 1);
    end

    // Late input_b_stb leaves the result and latency unchanged.
    run(32'h3FC0_0000, 32'h3FC0_0000, 5, z, lat);
    check("bdelay_z", z, 32'h4010_0000);
    check("bdelay_latency", lat, 35);

    // Reset in the middle of multiply_1, with a_stb held high across it.
    if (!aborted) begin
      send_a(32'h3FC0_0000);
      send_b(32'h3FC0_0000, 0);
      repeat (10) begin
        @(posedge clk); #1;
      end
      input_a = 32'h3FC0_0000;
      input_a_stb = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_a_ack", input_a_ack, 0);
      check("rst_b_ack", input_b_ack, 0);
      check("rst_z_stb", output_z_stb, 0);
      @(posedge clk); #1;
      check("rst_a_ack_rise", input_a_ack, 1);
      check("rst_no_result", output_z_stb, 0);
      run(32'h3FC0_0000, 32'h3FC0_0000, 0, z, lat);
      check("post_rst_z", z, 32'h4010_0000);
      check("post_rst_latency", lat, 35);
    end

    for (int i = 0; i < 200 && !aborted; i++) begin
      ra = rand_op();
      rb = rand_op();
      run(ra, rb, $urandom_range(0, 2), z, lat);
      check($sformatf("rand%0d_%08h_x_%08h", i, ra, rb), z, ref_mul(ra, rb));
    end

    check("ack_exclusive", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Single-precision IEEE 754 floating-point multiplier. It is the companion to the FPU divider and uses the same three-channel stb/ack stream handshake. Operands a and b are accepted one after the other, then multiplied with an iterative 24-cycle shift-add datapath. The result is rounded round-to-nearest-even and presented on z.

## Interface
- No parameters; fixed single precision (32-bit).
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset; overrides any state activity in the same edge.
- input_a  in  32  operand a (IEEE single).
- input_a_stb  in  1  producer asserts while input_a is valid.
- input_a_ack  out  1  block ready for a; transfer on an edge where ack && stb.
- input_b  in  32  operand b.
- input_b_stb  in  1  b valid.
- input_b_ack  out  1  ready for b.
- output_z  out  32  result; stable while output_z_stb is high.
- output_z_stb  out  1  result valid.
- output_z_ack  in  1  consumer accepts z; transfer on an edge where stb && ack.

## Operation
- Reset values: input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0. State returns to get_a.
- States: get_a, get_b, unpack, special_cases, normalise_a, normalise_b, multiply_0, multiply_1, multiply_2, normalise_1, normalise_2, round, pack, put_z.
- get_a / get_b:
  - The ack is driven to 1 on the first edge in the state.
  - On an edge where ack && stb, capture the operand, drop ack to 0 and advance to the next state.
- unpack:
  - Mantissa fields: m = bits[22:0].
  - Exponent fields: e = bits[30:23] − 127, held as 10-bit two's complement.
  - Sign fields: s = bit31.
- special_cases, checked in priority order. Sign below means a_s^b_s.
  - Either operand NaN (e=128, m≠0) → z=0xFFC00000.
  - a inf: b zero → 0xFFC00000; else signed inf (exp 255, m 0).
  - b inf: a zero → 0xFFC00000; else signed inf.
  - a or b zero (e=−127, m=0) → signed zero.
  - Every special case goes straight to put_z.
  - Otherwise, for each operand: if e=−127 set e=−126 (denormal), else set m[23]=1.
- normalise_a, normalise_b: one left shift of m and e−1 per cycle while m[23]=0; the state exits on the cycle m[23]=1.
- multiply_0:
  - z_s = a_s^b_s.
  - z_e = a_e + b_e + 1.
  - product(48b) = 0, count(5b) = 0.
- multiply_1:
  - Each cycle, if b_m[count], product += a_m << count.
  - Repeat for count 0..23, i.e. 24 cycles, then go to multiply_2.
- multiply_2:
  - z_m = product[47:24].
  - guard = product[23], round_bit = product[22].
  - sticky = |product[21:0].
- normalise_1: while z_m[23]=0, per cycle:
  - z_m = {z_m[22:0], guard}, guard = round_bit, round_bit = 0, z_e −1.
  - Exits on the cycle z_m[23]=1.
- normalise_2: while signed z_e < −126, per cycle:
  - z_m >>= 1, z_e +1.
  - guard = old z_m[0], round_bit = old guard, sticky |= old round_bit.
- round:
  - If guard && (round_bit | sticky | z_m[0]), then z_m +1.
  - If z_m was 0xFFFFFF before the increment, also z_e +1.
- pack:
  - z = {z_s, z_e[7:0]+127, z_m[22:0]}.
  - If z_e = −126 and z_m[23] = 0, exponent field = 0 (denormal).
  - If signed z_e > 127, z = signed inf.
- put_z:
  - output_z_stb=1 and output_z=z on the first edge in the state.
  - On an edge where stb && output_z_ack, drop stb to 0 and go to get_a.
  - output_z holds its value until the next result is loaded.

## Timing
- Handshakes:
  - Each ack/stb goes high one edge after entering its state.
  - A transfer occurs on the edge after the partner signal is seen high together with it; back-to-back transfers on consecutive edges are not possible.
  - input_a_ack and input_b_ack are never high at the same time.
- Latency is counted from the edge that captures b to the edge that raises output_z_stb.
  - Special cases: 3 edges.
  - Normal operands: 35 edges, plus one edge per shift in normalise_a, normalise_b, normalise_1 and normalise_2.
- After the z transfer edge, input_a_ack rises on the following edge.
- rst during any state: all acks/stb are 0 and the state is get_a after that edge. No partial result is ever emitted.
- stb/ack inputs sampled while rst=1 are ignored.

## Test plan
- 0x3FC00000 × 0x3FC00000 → 0x40100000 (2.25); output_z_stb rises exactly 35 edges after b capture. 0x40000000 × 0x40400000 → 0x40C00000 in 36 edges.
- Special cases:
  - 0x7FC00000 × 0x3F800000 → 0xFFC00000, in 3 edges.
  - 0x7F800000 × 0x00000000 → 0xFFC00000.
  - 0x7F800000 × 0xC0000000 → 0xFF800000.
  - 0x80000000 × 0x40000000 → 0x80000000.
- Overflow and rounding:
  - 0x7F7FFFFF × 0x40000000 → 0x7F800000.
  - 0x3F800001 × 0x3F800001 → 0x3F800002.
- Denormal path:
  - 0x00000001 × 0x3F000000 → 0x00000000 (tie to even).
  - 0x00000003 × 0x3F000000 → 0x00000002.
  - 0x00800000 × 0x3F000000 → 0x00400000.
- Backpressure: hold output_z_ack=0 for 10 cycles → stb stays high and z stays stable; raise ack → stb low on the next edge, input_a_ack high one edge later. Delay input_b_stb by 5 cycles → result unchanged.
- Assert rst for 1 cycle mid multiply_1 → acks/stb 0 after that edge, then input_a_ack=1 on the next edge. The following 1.5×1.5 transaction is correct.
